// File: rtl/aes128_package.sv
// Shared types, constants and helper functions for the AES128 masked datapath.
package aes128_package;

  typedef logic mul_id_t;

  localparam int MUL_ARB_FIFO_DEPTH = 2;

  // Number of share pairs (i<j); one r and one p word per pair.
  function automatic int num_quad(input int n);
    return (n * (n - 1)) / 2;
  endfunction

  function automatic int pair_index(input int i, input int j, input int n);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * n - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  // Reduction polynomial (without the x^w term); 8 bits uses the AES field.
  function automatic logic [7:0] gf_poly(input int w);
    return (w == 8) ? 8'h1B : 8'h00;
  endfunction

endpackage

// File: rtl/masked_hpc3_1_mul.sv
// HPC3-style masked multiplier with one register stage; operands are share-packed
// vectors, one r and one p word per share pair. GF(2^8) for 8-bit shares, AND for 1-bit.
module masked_hpc3_1_mul
  import aes128_package::*;
#(
  parameter int NUM_SHARES = 3,
  parameter int BIT_WIDTH  = 1,
  localparam int NUM_QUADRATIC = num_quad(NUM_SHARES),
  localparam int SHARE_W = NUM_SHARES * BIT_WIDTH,
  localparam int RAND_W  = NUM_QUADRATIC * BIT_WIDTH
) (
  input  logic               in_clock,
  input  logic               in_reset,
  input  logic [SHARE_W-1:0] in_a,
  input  logic [SHARE_W-1:0] in_b,
  input  logic [RAND_W-1:0]  in_r,
  input  logic [RAND_W-1:0]  in_p,
  output logic [SHARE_W-1:0] out_c
);

  localparam logic [BIT_WIDTH-1:0] GF_POLY = BIT_WIDTH'(gf_poly(BIT_WIDTH));

  function automatic logic [BIT_WIDTH-1:0] gf_mul(input logic [BIT_WIDTH-1:0] x,
                                                  input logic [BIT_WIDTH-1:0] y);
    logic [BIT_WIDTH-1:0] acc;
    logic [BIT_WIDTH-1:0] sh;
    acc = '0;
    sh  = x;
    for (int k = 0; k < BIT_WIDTH; k++) begin
      if (y[k]) acc = acc ^ sh;
      sh = (sh << 1) ^ (sh[BIT_WIDTH-1] ? GF_POLY : '0);
    end
    return acc;
  endfunction

  logic [BIT_WIDTH-1:0] t_mul [NUM_SHARES][NUM_SHARES];
  logic [BIT_WIDTH-1:0] t_msk [NUM_SHARES][NUM_SHARES];

  // Cross terms a_i*(b_j^r) and a_i*r^p are registered before compression;
  // each p word appears in both shares of its pair and cancels on recombination.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      for (int i = 0; i < NUM_SHARES; i++) begin
        for (int j = 0; j < NUM_SHARES; j++) begin
          t_mul[i][j] <= '0;
          t_msk[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < NUM_SHARES; i++) begin
        for (int j = 0; j < NUM_SHARES; j++) begin
          if (i == j) begin
            t_mul[i][j] <= gf_mul(in_a[i*BIT_WIDTH +: BIT_WIDTH], in_b[i*BIT_WIDTH +: BIT_WIDTH]);
            t_msk[i][j] <= '0;
          end else begin
            t_mul[i][j] <= gf_mul(in_a[i*BIT_WIDTH +: BIT_WIDTH],
                                  in_b[j*BIT_WIDTH +: BIT_WIDTH]
                                  ^ in_r[pair_index(i, j, NUM_SHARES)*BIT_WIDTH +: BIT_WIDTH]);
            t_msk[i][j] <= gf_mul(in_a[i*BIT_WIDTH +: BIT_WIDTH],
                                  in_r[pair_index(i, j, NUM_SHARES)*BIT_WIDTH +: BIT_WIDTH])
                           ^ in_p[pair_index(i, j, NUM_SHARES)*BIT_WIDTH +: BIT_WIDTH];
          end
        end
      end
    end
  end

  always_comb begin
    out_c = '0;
    for (int i = 0; i < NUM_SHARES; i++) begin
      for (int j = 0; j < NUM_SHARES; j++) begin
        out_c[i*BIT_WIDTH +: BIT_WIDTH] = out_c[i*BIT_WIDTH +: BIT_WIDTH] ^ t_mul[i][j] ^ t_msk[i][j];
      end
    end
  end

endmodule

// File: rtl/masked_mul_arbiter.sv
// Round-robin sharing of one masked_hpc3_1_mul between two requesters with a tagged
// 2-entry result FIFO. Option macro: MASKED_MUL_ARB_IDLE_ZERO_EN (zero gadget inputs when idle).
module masked_mul_arbiter
  import aes128_package::*;
#(
  parameter int NUM_SHARES = 3,
  parameter int BIT_WIDTH  = 1,
  localparam int NUM_QUADRATIC = num_quad(NUM_SHARES),
  localparam int SHARE_W = NUM_SHARES * BIT_WIDTH,
  localparam int RAND_W  = NUM_QUADRATIC * BIT_WIDTH
) (
  input  logic                    in_clock,
  input  logic                    in_reset,
  input  logic [1:0]              in_req_valid,
  output logic [1:0]              out_req_ready,
  input  logic [1:0][SHARE_W-1:0] in_req_a,
  input  logic [1:0][SHARE_W-1:0] in_req_b,
  input  logic                    in_rand_valid,
  output logic                    out_rand_ready,
  input  logic [RAND_W-1:0]       in_rand_r,
  input  logic [RAND_W-1:0]       in_rand_p,
  output logic                    out_res_valid,
  input  logic                    in_res_ready,
  output logic                    out_res_id,
  output logic [SHARE_W-1:0]      out_res_c
);

  localparam int CNT_W = $clog2(MUL_ARB_FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(MUL_ARB_FIFO_DEPTH);

  logic [CNT_W-1:0]   fifo_count;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [SHARE_W-1:0] fifo_c  [MUL_ARB_FIFO_DEPTH];
  mul_id_t            fifo_id [MUL_ARB_FIFO_DEPTH];

  logic    s1_valid;
  mul_id_t s1_id;
  mul_id_t prio;

  logic    credit_ok;
  logic    issue;
  mul_id_t grant;
  logic    fifo_empty;
  logic    pop;
  logic    pop_fifo;
  logic    push;

  logic [SHARE_W-1:0] gadget_a;
  logic [SHARE_W-1:0] gadget_b;
  logic [SHARE_W-1:0] gadget_c;
  logic [RAND_W-1:0]  gadget_r;
  logic [RAND_W-1:0]  gadget_p;

  // Results already queued plus the one in the gadget must leave a free FIFO slot.
  assign credit_ok = ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(s1_valid))
                     < (CNT_W+1)'(MUL_ARB_FIFO_DEPTH);
  assign grant          = (&in_req_valid) ? prio : in_req_valid[1];
  assign issue          = ~in_reset & (|in_req_valid) & in_rand_valid & credit_ok;
  assign out_req_ready  = issue ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign out_rand_ready = issue;

`ifdef MASKED_MUL_ARB_IDLE_ZERO_EN
  always_comb begin
    gadget_a = '0;
    gadget_b = '0;
    gadget_r = '0;
    gadget_p = '0;
    if (issue) begin
      gadget_a = in_req_a[grant];
      gadget_b = in_req_b[grant];
      gadget_r = in_rand_r;
      gadget_p = in_rand_p;
    end
  end
`else
  mul_id_t sel;

  assign sel      = issue ? grant : prio;
  assign gadget_a = in_req_a[sel];
  assign gadget_b = in_req_b[sel];
  assign gadget_r = in_rand_r;
  assign gadget_p = in_rand_p;
`endif

  masked_hpc3_1_mul #(
    .NUM_SHARES(NUM_SHARES),
    .BIT_WIDTH (BIT_WIDTH)
  ) u_mul (
    .in_clock(in_clock),
    .in_reset(in_reset),
    .in_a    (gadget_a),
    .in_b    (gadget_b),
    .in_r    (gadget_r),
    .in_p    (gadget_p),
    .out_c   (gadget_c)
  );

  // An empty FIFO lets the gadget output fall through, giving issue-to-head latency of one cycle.
  assign fifo_empty    = (fifo_count == '0);
  assign out_res_valid = ~fifo_empty | s1_valid;

  always_comb begin
    out_res_id = 1'b0;
    out_res_c  = '0;
    if (!fifo_empty) begin
      out_res_id = fifo_id[rd_ptr];
      out_res_c  = fifo_c[rd_ptr];
    end else if (s1_valid) begin
      out_res_id = s1_id;
      out_res_c  = gadget_c;
    end
  end

  assign pop      = out_res_valid & in_res_ready;
  assign pop_fifo = pop & ~fifo_empty;
  assign push     = s1_valid & ~(fifo_empty & pop);

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      s1_valid   <= 1'b0;
      s1_id      <= 1'b0;
      prio       <= 1'b0;
    end else begin
      s1_valid <= issue;
      if (issue) begin
        s1_id <= grant;
        prio  <= ~grant;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_fifo) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop_fifo);
    end
  end

  always_ff @(posedge in_clock) begin
    if (push) begin
      fifo_c[wr_ptr]  <= gadget_c;
      fifo_id[wr_ptr] <= s1_id;
    end
  end

endmodule
